// File: rtl/bcd_scan_pkg.sv
// Shared constants and types for the 4-digit BCD scan counter.
// Imported by the decade cell and the top.
package bcd_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] AN_RESET = 4'b1110;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the counter: inc/dec with wrap, clamp-on-load,
// and combinational carry/borrow out for the ripple chain.
module bcd_digit
  import bcd_scan_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_up,
  input  logic       i_cin,
  output logic [3:0] o_digit,
  output logic       o_cout
);

  logic [3:0] r_digit;
  logic       w_at_max;
  logic       w_at_min;

  assign w_at_max = (r_digit == BCD_MAX);
  assign w_at_min = (r_digit == 4'd0);
  assign o_cout   = i_cin & (i_up ? w_at_max : w_at_min);
  assign o_digit  = r_digit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= clamp_bcd(i_load_val);
    end else if (i_cin) begin
      if (i_up)
        r_digit <= w_at_max ? 4'd0 : r_digit + 4'd1;
      else
        r_digit <= w_at_min ? BCD_MAX : r_digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// 4-digit BCD up/down counter with prescaled stepping and a
// time-multiplexed digit scanner feeding a 7-segment decoder.
module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int COUNT_DIV = 100000,
  parameter int SCAN_DIV  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [3:0]  an,
  output logic [15:0] value,
  output logic        carry
);

  localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0]       r_cdiv;
  logic [SW-1:0]       r_sdiv;
  digit_idx_t          r_idx;
  logic [3:0]          r_bcd;
  logic [3:0]          r_an;
  logic                r_carry;
  logic                w_step;
  logic                w_cend;
  logic                w_send;
  logic [3:0]          w_digit [NUM_DIGITS];
  logic [NUM_DIGITS:0] w_chain;
  logic [15:0]         w_value;

  assign w_cend = (r_cdiv == CW'(COUNT_DIV - 1));
  assign w_send = (r_sdiv == SW'(SCAN_DIV - 1));
  assign w_step = en & w_cend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cdiv <= '0;
    else if (load)
      r_cdiv <= '0;
    else if (en)
      r_cdiv <= w_cend ? '0 : r_cdiv + 1'b1;
  end

  assign w_chain[0] = w_step;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_digit (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_load     (load),
      .i_load_val (load_val[4*g +: 4]),
      .i_up       (up),
      .i_cin      (w_chain[g]),
      .o_digit    (w_digit[g]),
      .o_cout     (w_chain[g+1])
    );
  end

  // A load in the same cycle as a wrap swallows the carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_carry <= 1'b0;
    else
      r_carry <= w_chain[NUM_DIGITS] & ~load;
  end

  always_comb begin
    w_value = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_value[4*i +: 4] = w_digit[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sdiv <= '0;
      r_idx  <= '0;
    end else if (w_send) begin
      r_sdiv <= '0;
      r_idx  <= r_idx + 2'd1;
    end else begin
      r_sdiv <= r_sdiv + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd <= 4'd0;
      r_an  <= AN_RESET;
    end else begin
      r_bcd <= w_digit[r_idx];
      r_an  <= ~(4'b0001 << r_idx);
    end
  end

  assign {a, b, c, d} = r_bcd;
  assign an    = r_an;
  assign value = w_value;
  assign carry = r_carry;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed, table-driven bench for bcd_scan_counter
// with COUNT_DIV = 4 and SCAN_DIV = 2.
module tb_bcd_scan_counter;

  localparam int CD = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic        a, b, c, d;
  logic [3:0]  an;
  logic [15:0] value;
  logic        carry;

  always #5 clk = ~clk;

  bcd_scan_counter #(
    .COUNT_DIV (CD),
    .SCAN_DIV  (SD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .an       (an),
    .value    (value),
    .carry    (carry)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] lv;
    logic        en;
    logic        up;
    int          cyc;
    logic [15:0] ev;
    logic        ec;
    string       nm;
  } vec_t;

  vec_t vt [24];

  logic [3:0] sc_an  [8];
  logic [3:0] sc_bcd [8];

  initial begin
    vt[0]  = '{1'b1, 16'h9999, 1'b0, 1'b1, 1, 16'h9999, 1'b0, "ld9999"};
    vt[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 3, 16'h9999, 1'b0, "pre_wrap_up"};
    vt[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1, 16'h0000, 1'b1, "wrap_up"};
    vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1, 16'h0000, 1'b0, "wrap_up_1cyc"};
    vt[4]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1, 16'h0000, 1'b0, "ld0000"};
    vt[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h0000, 1'b0, "pre_wrap_dn"};
    vt[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h9999, 1'b1, "wrap_dn"};
    vt[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h9999, 1'b0, "wrap_dn_1cyc"};
    vt[8]  = '{1'b1, 16'hA3F5, 1'b0, 1'b0, 1, 16'h9395, 1'b0, "clamp"};
    vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 3, 16'h9395, 1'b0, "pre_ld_step"};
    vt[10] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1, 16'h1234, 1'b0, "ld_vs_step"};
    vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 3, 16'h1234, 1'b0, "presc_clr"};
    vt[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1, 16'h1235, 1'b0, "step_after_ld"};
    vt[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2, 16'h1235, 1'b0, "part_count"};
    vt[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 5, 16'h1235, 1'b0, "en_freeze"};
    vt[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1, 16'h1235, 1'b0, "presc_kept"};
    vt[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1, 16'h1236, 1'b0, "step_resume"};
    vt[17] = '{1'b1, 16'h1000, 1'b1, 1'b0, 1, 16'h1000, 1'b0, "ld1000"};
    vt[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4, 16'h0999, 1'b0, "borrow_ripple"};
    vt[19] = '{1'b1, 16'h9999, 1'b1, 1'b1, 1, 16'h9999, 1'b0, "ld9999_b"};
    vt[20] = '{1'b0, 16'h0000, 1'b1, 1'b1, 3, 16'h9999, 1'b0, "pre_ld_wrap"};
    vt[21] = '{1'b1, 16'h9999, 1'b1, 1'b1, 1, 16'h9999, 1'b0, "ld_kills_carry"};
    vt[22] = '{1'b0, 16'h0000, 1'b1, 1'b1, 3, 16'h9999, 1'b0, "pre_wrap_b"};
    vt[23] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1, 16'h0000, 1'b1, "wrap_up_b"};

    sc_an  = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
               4'b1011, 4'b1011, 4'b0111, 4'b0111};
    sc_bcd = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};

    rst      = 1'b1;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 16'h0000;
    #12;
    chk("rst_value", value, 16'h0000);
    chk("rst_an", an, 4'b1110);
    chk("rst_abcd", {a, b, c, d}, 4'h0);
    chk("rst_carry", carry, 1'b0);

    @(posedge clk);
    #1;
    rst = 1'b0;

    en = 1'b1;
    up = 1'b1;
    tick(3);
    chk("up_no_step_yet", value, 16'h0000);
    tick(1);
    chk("up_first_step", value, 16'h0001);
    tick(36);
    chk("up_step10", value, 16'h0010);

    for (int i = 0; i < 24; i++) begin
      load     = vt[i].ld;
      load_val = vt[i].lv;
      en       = vt[i].en;
      up       = vt[i].up;
      tick(vt[i].cyc);
      chk({vt[i].nm, "_value"}, value, vt[i].ev);
      chk({vt[i].nm, "_carry"}, carry, vt[i].ec);
    end
    load = 1'b0;

    // carry is high here; reset must drop it with no edge
    #3;
    rst = 1'b1;
    #1;
    chk("async_carry", carry, 1'b0);
    chk("async_value", value, 16'h0000);
    chk("async_an", an, 4'b1110);
    chk("async_abcd", {a, b, c, d}, 4'h0);

    @(posedge clk);
    #1;
    rst      = 1'b0;
    en       = 1'b0;
    load     = 1'b1;
    load_val = 16'h4321;
    tick(1);
    load = 1'b0;
    chk("scan_ld", value, 16'h4321);

    begin
      int k;
      k = 0;
      while (an !== 4'b0111 && k < 20) begin
        tick(1);
        k++;
      end
      while (an !== 4'b1110 && k < 40) begin
        tick(1);
        k++;
      end
      chk("scan_sync_timeout", (k < 40), 1'b1);
    end

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("scan_an_%0d", i), an, sc_an[i]);
      chk($sformatf("scan_abcd_%0d", i), {a, b, c, d}, sc_bcd[i]);
      tick(1);
    end
    chk("scan_frozen", value, 16'h4321);
    chk("scan_carry", carry, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
